// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute ALU and the ALU-control decoder.
// Function codes, FSM states, shift kinds and the default datapath width.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    // Function-code encoding shared with the ALU-control decoder
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;
    localparam logic [5:0] FN_LUI   = 6'h3C;
    localparam logic [5:0] FN_ROTR  = 6'h3E;
    localparam logic [5:0] FN_ROTRV = 6'h3F;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } alu_state_t;

    typedef enum logic [1:0] {
        SK_LEFT,
        SK_SRL,
        SK_SRA,
        SK_ROT
    } shift_kind_t;

    // True for every shift/rotate code (immediate and variable forms alike)
    function automatic logic is_shift_fn(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SLLV, FN_SRL, FN_SRLV,
            FN_SRA, FN_SRAV, FN_ROTR, FN_ROTRV: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Direction/fill kind of a shift code; non-shift codes map to SK_LEFT
    function automatic shift_kind_t shift_kind_of(input logic [5:0] fn);
        case (fn)
            FN_SRL, FN_SRLV:   return SK_SRL;
            FN_SRA, FN_SRAV:   return SK_SRA;
            FN_ROTR, FN_ROTRV: return SK_ROT;
            default:           return SK_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_shifter.sv
// Shift/rotate engine for mc_alu.
// Default build: iterative, one bit position per cycle, with its own shift
// register, down-counter and latched op kind.
// With MC_ALU_BARREL_EN defined: purely combinational barrel shifter
// (busy tied low, last tied high, no clock or load needed).
module mc_alu_shifter
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
`ifndef MC_ALU_BARREL_EN
    input  logic                clk,
    input  logic                srst,
    input  logic                load,
`endif
    input  logic [DATA_W-1:0]   value,
    input  logic [SHAMT_W-1:0]  amt,
    input  shift_kind_t         kind,
    output logic                busy,
    output logic                last,
    output logic [DATA_W-1:0]   out
);

`ifdef MC_ALU_BARREL_EN

    logic [DATA_W-1:0] rot_bits;

    // Rotate right: output bit i comes from bit (i+amt) mod DATA_W; the
    // SHAMT_W-wide sum wraps naturally because DATA_W is a power of two
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_rot
            assign rot_bits[gi] = value[SHAMT_W'(gi) + amt];
        end
    endgenerate

    // Full-distance shift in one combinational pass
    always_comb begin
        out = value;
        case (kind)
            SK_LEFT: out = value << amt;
            SK_SRL:  out = value >> amt;
            SK_SRA:  out = $signed(value) >>> amt;
            SK_ROT:  out = rot_bits;
            default: out = value;
        endcase
    end

    assign busy = 1'b0;
    assign last = 1'b1;

`else

    logic [DATA_W-1:0]  shreg_reg;
    logic [SHAMT_W-1:0] count_reg;
    shift_kind_t        kind_reg;

    // One bit position of the selected kind
    function automatic logic [DATA_W-1:0] step1(input logic [DATA_W-1:0] v,
                                                input shift_kind_t k);
        case (k)
            SK_LEFT: return {v[DATA_W-2:0], 1'b0};
            SK_SRL:  return {1'b0, v[DATA_W-1:1]};
            SK_SRA:  return {v[DATA_W-1], v[DATA_W-1:1]};
            SK_ROT:  return {v[0], v[DATA_W-1:1]};
            default: return v;
        endcase
    endfunction

    // Load operand/amount/kind, then step once per cycle until the count runs out
    always_ff @(posedge clk) begin
        if (srst) begin
            shreg_reg <= '0;
            count_reg <= '0;
            kind_reg  <= SK_LEFT;
        end else if (load) begin
            shreg_reg <= value;
            count_reg <= amt;
            kind_reg  <= kind;
        end else if (count_reg != '0) begin
            shreg_reg <= step1(shreg_reg, kind_reg);
            count_reg <= count_reg - 1'b1;
        end
    end

    // out is the value after the step in progress, so the final step's result
    // can be captured by the parent on the same edge the counter hits zero
    assign out  = step1(shreg_reg, kind_reg);
    assign busy = (count_reg != '0);
    assign last = (count_reg == SHAMT_W'(1));

`endif

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle execute-stage ALU with start/done handshake.
// Logic/arithmetic/compare/LUI codes complete one cycle after acceptance;
// shifts and rotates use mc_alu_shifter and take amt+1 cycles unless the
// optional macro MC_ALU_BARREL_EN selects the single-cycle barrel shifter.
module mc_alu
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [5:0]        i_aluControl,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_illegal
);

    alu_state_t         state_reg, state_next;
    logic               done_reg, done_next;
    logic [DATA_W-1:0]  result_reg, result_next;
    logic               zero_reg, zero_next;
    logic               illegal_reg, illegal_next;

    logic [DATA_W-1:0]  alu_res;
    logic               alu_ill;
    logic [SHAMT_W-1:0] shamt;
    logic               sh_busy;
    logic               sh_last;
    logic [DATA_W-1:0]  sh_out;
    logic               fin;
    logic [DATA_W-1:0]  fin_val;
    logic               fin_ill;

    assign shamt = i_op1[SHAMT_W-1:0];

    // Single-cycle datapath; shift codes fall through as legal but unused here
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (i_aluControl)
            FN_ADD, FN_ADDU: alu_res = i_op1 + i_op2;
            FN_SUB, FN_SUBU: alu_res = i_op1 - i_op2;
            FN_AND:          alu_res = i_op1 & i_op2;
            FN_OR:           alu_res = i_op1 | i_op2;
            FN_XOR:          alu_res = i_op1 ^ i_op2;
            FN_NOR:          alu_res = ~(i_op1 | i_op2);
            FN_SLT:          alu_res = {{(DATA_W-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            FN_SLTU:         alu_res = {{(DATA_W-1){1'b0}}, (i_op1 < i_op2)};
            FN_LUI:          alu_res = {i_op2[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            default:         alu_ill = ~is_shift_fn(i_aluControl);
        endcase
    end

`ifdef MC_ALU_BARREL_EN
    mc_alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .value (i_op2),
        .amt   (shamt),
        .kind  (shift_kind_of(i_aluControl)),
        .busy  (sh_busy),
        .last  (sh_last),
        .out   (sh_out)
    );
`else
    logic sh_load;

    mc_alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk   (i_clk),
        .srst  (i_rst),
        .load  (sh_load),
        .value (i_op2),
        .amt   (shamt),
        .kind  (shift_kind_of(i_aluControl)),
        .busy  (sh_busy),
        .last  (sh_last),
        .out   (sh_out)
    );
`endif

    // Next-state and completion logic: accept in IDLE, finish in IDLE or on the last shift step
    always_comb begin
        state_next   = state_reg;
        done_next    = 1'b0;
        result_next  = result_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        fin          = 1'b0;
        fin_val      = '0;
        fin_ill      = 1'b0;
`ifndef MC_ALU_BARREL_EN
        sh_load      = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    if (is_shift_fn(i_aluControl)) begin
`ifdef MC_ALU_BARREL_EN
                        fin     = 1'b1;
                        fin_val = sh_out;
`else
                        if (shamt == '0) begin
                            fin     = 1'b1;
                            fin_val = i_op2;
                        end else begin
                            sh_load    = 1'b1;
                            state_next = ST_SHIFT;
                        end
`endif
                    end else begin
                        fin     = 1'b1;
                        fin_val = alu_res;
                        fin_ill = alu_ill;
                    end
                end
            end
`ifndef MC_ALU_BARREL_EN
            ST_SHIFT: begin
                if (sh_last) begin
                    fin        = 1'b1;
                    fin_val    = sh_out;
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
        if (fin) begin
            done_next    = 1'b1;
            result_next  = fin_val;
            zero_next    = (fin_val == '0);
            illegal_next = fin_ill;
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            done_reg    <= done_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
        end
    end

    assign o_busy    = sh_busy;
    assign o_done    = done_reg;
    assign o_result  = result_reg;
    assign o_zero    = zero_reg;
    assign o_illegal = illegal_reg;

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu: cycle-level behavioural model compared on
// every cycle, plus directed cases with hand-computed literal results.
module tb_mc_alu;

`ifdef MC_ALU_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  code = 6'h00;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        busy, done, zero, illegal;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;

    mc_alu dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_aluControl (code),
        .i_op1        (op1),
        .i_op2        (op2),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result),
        .o_zero       (zero),
        .o_illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_shift(input logic [5:0] c);
        return (c == 6'h00 || c == 6'h04 || c == 6'h02 || c == 6'h06 ||
                c == 6'h03 || c == 6'h07 || c == 6'h3E || c == 6'h3F);
    endfunction

    // Reference result straight from the operation definitions
    function automatic logic [31:0] ref_res(input logic [5:0] c, input logic [31:0] a,
                                            input logic [31:0] b, output bit ill);
        int amt;
        amt = int'(a[4:0]);
        ill = 1'b0;
        case (c)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h3C: return {b[15:0], 16'h0000};
            6'h00, 6'h04: return b << amt;
            6'h02, 6'h06: return b >> amt;
            6'h03, 6'h07: return $signed(b) >>> amt;
            6'h3E, 6'h3F: return (amt == 0) ? b : ((b >> amt) | (b << (32 - amt)));
            default: begin ill = 1'b1; return 32'h0; end
        endcase
    endfunction

    // Model: countdown of remaining cycles for the one operation in flight
    int          m_rem = 0;
    bit          m_busy = 0, m_done = 0, m_zero = 0, m_ill = 0;
    logic [31:0] m_res = '0, m_pend = '0;

    always @(posedge clk) begin
        bit          ill;
        logic [31:0] r;
        int          lat;
        if (rst) begin
            m_rem = 0; m_busy = 0; m_done = 0; m_res = '0; m_zero = 0; m_ill = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0; m_done = 1; m_res = m_pend; m_zero = (m_pend == 0); m_ill = 0;
                end
            end else if (start) begin
                r   = ref_res(code, op1, op2, ill);
                lat = (is_shift(code) && !BARREL) ? int'(op1[4:0]) : 0;
                if (lat == 0) begin
                    m_done = 1; m_res = r; m_zero = (r == 0); m_ill = ill;
                end else begin
                    m_rem = lat; m_busy = 1; m_pend = r;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("result", result, m_res);
        chk("zero", {31'b0, zero}, {31'b0, m_zero});
        chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
    end

    // Directed operation with literal expectations; bounded wait for o_done
    task automatic run_op(input string name, input logic [5:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit exp_ill);
        int lat;
        bit got;
        @(negedge clk);
        start = 1'b1; code = c; op1 = a; op2 = b;
        lat = 0; got = 0;
        while (lat < 64 && !got) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) got = 1;
        end
        chk({name, " done_seen"}, {31'b0, got}, 32'd1);
        if (got) begin
            chk({name, " latency"}, lat, exp_lat);
            chk({name, " result"}, result, exp_res);
            chk({name, " zero"}, {31'b0, zero}, {31'b0, (exp_res == 0)});
            chk({name, " illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
        end
        $display("op %s code=%h op1=%h op2=%h -> result=%h latency=%0d", name, c, a, b, result, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [5:0] codes [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h3C, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03,
                               6'h07, 6'h3E, 6'h3F, 6'h15};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'b0, zero}, 32'd0);
        chk("reset illegal", {31'b0, illegal}, 32'd0);

        run_op("ADD wrap", 6'h20, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);

        // Back-to-back single-cycle requests
        @(negedge clk);
        start = 1'b1; code = 6'h2A; op1 = 32'hFFFF_FFFE; op2 = 32'h1;
        @(negedge clk);
        chk("SLT done", {31'b0, done}, 32'd1);
        chk("SLT result", result, 32'd1);
        code = 6'h2B;
        @(negedge clk);
        start = 1'b0;
        chk("SLTU done", {31'b0, done}, 32'd1);
        chk("SLTU result", result, 32'd0);
        $display("op SLT/SLTU back-to-back done");

`ifndef MC_ALU_BARREL_EN
        // SRA with an ignored start while busy
        begin
            int lat;
            bit got;
            @(negedge clk);
            start = 1'b1; code = 6'h03; op1 = 32'h4; op2 = 32'h8000_0010;
            @(negedge clk);
            code = 6'h20; op1 = 32'h1; op2 = 32'h1;
            lat = 1; got = 0;
            while (lat < 64 && !got) begin
                @(negedge clk);
                start = 1'b0;
                lat++;
                if (done) got = 1;
                else chk("SRA busy while shifting", {31'b0, busy}, 32'd1);
            end
            chk("SRA latency", lat, 5);
            chk("SRA result", result, 32'hF800_0001);
            chk("SRA busy at done", {31'b0, busy}, 32'd0);
            @(negedge clk);
            chk("SRA no extra done", {31'b0, done}, 32'd0);
            $display("op SRA with ignored start -> result=%h latency=%0d", result, lat);
        end
`endif
        run_op("SRA", 6'h03, 32'h4, 32'h8000_0010, 32'hF800_0001, BARREL ? 1 : 5, 0);
        run_op("ROTRV", 6'h3F, 32'h21, 32'h3, 32'h8000_0001, BARREL ? 1 : 2, 0);
        run_op("SLL amt0", 6'h00, 32'h0, 32'h1234, 32'h1234, 1, 0);
        run_op("illegal", 6'h15, 32'h5, 32'h7, 32'h0, 1, 1);
        run_op("LUI", 6'h3C, 32'h0, 32'h0000_ABCD, 32'hABCD_0000, 1, 0);

        // Reset in the middle of a long shift
        @(negedge clk);
        start = 1'b1; code = 6'h02; op1 = 32'd20; op2 = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort zero", {31'b0, zero}, 32'd0);
        repeat (25) begin
            @(negedge clk);
            chk("abort no late done", {31'b0, done}, 32'd0);
        end
        $display("op SRL amt=20 aborted by reset");

        // Randomised traffic, including ignored starts and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            code  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                               : codes[$urandom_range(0, 19)];
            op1   = $urandom;
            op2   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) op1[4:0] = 5'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
